mempool_tcdm_port_cut: RTL and testbench

// Parametrised TCDM data-port decoupler placed between a Snitch core and the tile TCDM

---
 rtl/mempool_tcdm_port_cut_if.sv | 28 ++
 rtl/mempool_tcdm_port_cut.sv | 114 +++++++++++
 tb/tb_mempool_tcdm_port_cut.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mempool_tcdm_port_cut_if.sv
// mempool_tcdm_port_cut_if: TCDM request/response port bundle between a core and the interconnect
interface mempool_tcdm_port_cut_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 5
);
  logic [AddrWidth-1:0]   qaddr;
  logic                   qwrite;
  logic [3:0]             qamo;
  logic [DataWidth-1:0]   qdata;
  logic [DataWidth/8-1:0] qstrb;
  logic [IdWidth-1:0]     qid;
  logic                   qvalid;
  logic                   qready;
  logic [DataWidth-1:0]   pdata;
  logic                   perror;
  logic [IdWidth-1:0]     pid;
  logic                   pvalid;
  logic                   pready;
  modport master (
    output qaddr, qwrite, qamo, qdata, qstrb, qid, qvalid, pready,
    input  qready, pdata, perror, pid, pvalid
  );
  modport slave (
    input  qaddr, qwrite, qamo, qdata, qstrb, qid, qvalid, pready,
    output qready, pdata, perror, pid, pvalid
  );
endinterface

// File: rtl/mempool_tcdm_port_cut.sv
// mempool_tcdm_port_cut: credit-limited TCDM port decoupler with configurable request/response register cuts
module mempool_tcdm_port_cut_spill #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);
  logic             a_full, b_full;
  logic [Width-1:0] a_data, b_data;
  logic             a_fill, a_drain, b_fill, b_drain;
  assign ready_o = !a_full || !b_full;
  assign valid_o = a_full || b_full;
  assign data_o  = b_full ? b_data : a_data;
  assign a_fill  = valid_i && ready_o;
  assign a_drain = a_full && !b_full;
  assign b_fill  = a_drain && !ready_i;
  assign b_drain = b_full && ready_i;
  // A captures the input; B catches A's entry when the output stalls, so ready never depends on ready_i
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      a_full <= 1'b0;
      b_full <= 1'b0;
      a_data <= '0;
      b_data <= '0;
    end else begin
      a_full <= a_fill || (a_full && !a_drain);
      b_full <= b_fill || (b_full && !b_drain);
      a_data <= a_fill ? data_i : a_data;
      b_data <= b_fill ? a_data : b_data;
    end
endmodule

module mempool_tcdm_port_cut #(
  parameter  int unsigned AddrWidth      = 32,
  parameter  int unsigned DataWidth      = 32,
  parameter  int unsigned IdWidth        = 5,
  parameter  int unsigned NumReqCuts     = 1,
  parameter  int unsigned NumRespCuts    = 0,
  parameter  int unsigned MaxOutstanding = 8,
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  mempool_tcdm_port_cut_if.slave  core,
  mempool_tcdm_port_cut_if.master mem,
  output logic [CntW-1:0]         outstanding_o,
  output logic [31:0]             stall_cnt_o,
  output logic                    err_o
);
  localparam int unsigned ReqW = AddrWidth + 5 + DataWidth + DataWidth / 8 + IdWidth;
  localparam int unsigned RspW = DataWidth + 1 + IdWidth;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
  if (NumReqCuts > 3 || NumRespCuts > 3 || MaxOutstanding < 1 || DataWidth % 8 != 0) begin : g_bad_params
    $error("mempool_tcdm_port_cut: invalid parameter set");
  end
  logic [NumReqCuts:0]  req_valid, req_ready;
  logic [ReqW-1:0]      req_data [NumReqCuts+1];
  logic [NumRespCuts:0] rsp_valid, rsp_ready;
  logic [RspW-1:0]      rsp_data [NumRespCuts+1];
  logic                 credit_ok, req_hs, rsp_hs;
  assign credit_ok   = outstanding_o < MaxCnt;
  assign req_valid[0] = core.qvalid && credit_ok;
  assign core.qready  = req_ready[0] && credit_ok;
  assign req_data[0]  = {core.qaddr, core.qwrite, core.qamo, core.qdata, core.qstrb, core.qid};
  assign mem.qvalid   = req_valid[NumReqCuts];
  assign req_ready[NumReqCuts] = mem.qready;
  assign {mem.qaddr, mem.qwrite, mem.qamo, mem.qdata, mem.qstrb, mem.qid} = req_data[NumReqCuts];
  assign rsp_valid[0] = mem.pvalid;
  assign mem.pready   = rsp_ready[0];
  assign rsp_data[0]  = {mem.pdata, mem.perror, mem.pid};
  assign core.pvalid  = rsp_valid[NumRespCuts];
  assign rsp_ready[NumRespCuts] = core.pready;
  assign {core.pdata, core.perror, core.pid} = rsp_data[NumRespCuts];
  for (genvar i = 0; i < NumReqCuts; i++) begin : g_req_cut
    mempool_tcdm_port_cut_spill #(.Width(ReqW)) u_cut (
      .clk_i, .rst_ni,
      .valid_i(req_valid[i]), .ready_o(req_ready[i]), .data_i(req_data[i]),
      .valid_o(req_valid[i+1]), .ready_i(req_ready[i+1]), .data_o(req_data[i+1])
    );
  end
  for (genvar i = 0; i < NumRespCuts; i++) begin : g_rsp_cut
    mempool_tcdm_port_cut_spill #(.Width(RspW)) u_cut (
      .clk_i, .rst_ni,
      .valid_i(rsp_valid[i]), .ready_o(rsp_ready[i]), .data_i(rsp_data[i]),
      .valid_o(rsp_valid[i+1]), .ready_i(rsp_ready[i+1]), .data_o(rsp_data[i+1])
    );
  end
  assign req_hs = core.qvalid && core.qready;
  assign rsp_hs = core.pvalid && core.pready;
  // In-flight count: core-side handshakes only, never wraps below zero
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) outstanding_o <= '0;
    else if (req_hs && !rsp_hs) outstanding_o <= outstanding_o + CntW'(1);
    else if (rsp_hs && !req_hs && outstanding_o != '0) outstanding_o <= outstanding_o - CntW'(1);
  // Saturating stall counter and sticky orphan-response flag; clear has priority
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      stall_cnt_o <= '0;
      err_o       <= 1'b0;
    end else if (clr_i) begin
      stall_cnt_o <= '0;
      err_o       <= 1'b0;
    end else begin
      stall_cnt_o <= (core.qvalid && !core.qready && stall_cnt_o != '1) ? stall_cnt_o + 32'd1 : stall_cnt_o;
      err_o       <= err_o || (rsp_hs && outstanding_o == '0);
    end
endmodule

// File: tb/tb_mempool_tcdm_port_cut.sv
// tb_mempool_tcdm_port_cut: scoreboard bench for two cut/credit configurations of the port decoupler
module tb_mempool_tcdm_port_cut;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [4:0] id; logic [31:0] data;} txn_t;

  mempool_tcdm_port_cut_if ca(), ma(), cb(), mb();
  logic [1:0]  out_a;
  logic [4:0]  out_b;
  logic [31:0] stall_a, stall_b;
  logic        err_a, err_b;
  int          checks = 0, passes = 0;

  mempool_tcdm_port_cut #(.NumReqCuts(1), .NumRespCuts(0), .MaxOutstanding(2)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .core(ca), .mem(ma),
    .outstanding_o(out_a), .stall_cnt_o(stall_a), .err_o(err_a));
  mempool_tcdm_port_cut #(.NumReqCuts(3), .NumRespCuts(3), .MaxOutstanding(16)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .core(cb), .mem(mb),
    .outstanding_o(out_b), .stall_cnt_o(stall_b), .err_o(err_b));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    {ca.qaddr, ca.qwrite, ca.qamo, ca.qdata, ca.qstrb, ca.qid, ca.qvalid} = '0;
    {cb.qaddr, cb.qwrite, cb.qamo, cb.qdata, cb.qstrb, cb.qid, cb.qvalid} = '0;
    {ma.pdata, ma.perror, ma.pid, ma.pvalid} = '0;
    {mb.pdata, mb.perror, mb.pid, mb.pvalid} = '0;
    ma.qready = 1'b1; mb.qready = 1'b1; ca.pready = 1'b1; cb.pready = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ma.qvalid !== 1'b0) $display("FAIL rst_mem_qvalid: got %b want 0", ma.qvalid); else passes++;
    checks++; if (ca.pvalid !== 1'b0) $display("FAIL rst_core_pvalid: got %b want 0", ca.pvalid); else passes++;
    checks++; if (out_a !== 2'd0) $display("FAIL rst_outstanding: got %0d want 0", out_a); else passes++;
    checks++; if (stall_a !== 32'd0) $display("FAIL rst_stall: got %0d want 0", stall_a); else passes++;
    checks++; if (err_a !== 1'b0) $display("FAIL rst_err: got %b want 0", err_a); else passes++;
    checks++; if (ca.qready !== 1'b1) $display("FAIL rst_core_qready: got %b want 1", ca.qready); else passes++;
    checks++; if (mb.qvalid !== 1'b0 || cb.pvalid !== 1'b0 || out_b !== 5'd0) $display("FAIL rst_b_idle: qv %b pv %b out %0d want 0 0 0", mb.qvalid, cb.pvalid, out_b); else passes++;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_single();
    txn_t exp_q[$];
    txn_t e;
    @(negedge clk);
    ca.qaddr = 32'h100; ca.qid = 5'd3; ca.qwrite = 1'b0; ca.qvalid = 1'b1;
    #1;
    checks++; if (ca.qready !== 1'b1) $display("FAIL single_qready: got %b want 1", ca.qready); else passes++;
    exp_q.push_back('{id: 5'd3, data: 32'hCAFE0100});
    @(negedge clk);
    ca.qvalid = 1'b0;
    #1;
    checks++; if (ma.qvalid !== 1'b1) $display("FAIL single_mem_qvalid: got %b want 1", ma.qvalid); else passes++;
    checks++; if (ma.qaddr !== 32'h100 || ma.qid !== 5'd3) $display("FAIL single_mem_fields: addr %0h id %0d want 100 3", ma.qaddr, ma.qid); else passes++;
    checks++; if (out_a !== 2'd1) $display("FAIL single_out1: got %0d want 1", out_a); else passes++;
    @(negedge clk);
    ma.pvalid = 1'b1; ma.pid = 5'd3; ma.pdata = 32'hCAFE0100; ma.perror = 1'b0;
    #1;
    checks++; if (ma.qvalid !== 1'b0) $display("FAIL single_no_dup: got %b want 0", ma.qvalid); else passes++;
    checks++;
    if (!ca.pvalid || exp_q.size() == 0) $display("FAIL single_rsp: pvalid %b want 1", ca.pvalid);
    else begin
      e = exp_q.pop_front();
      if (ca.pid !== e.id || ca.pdata !== e.data) $display("FAIL single_rsp: id %0d data %0h want %0d %0h", ca.pid, ca.pdata, e.id, e.data); else passes++;
    end
    @(negedge clk);
    ma.pvalid = 1'b0;
    #1;
    checks++; if (out_a !== 2'd0 || err_a !== 1'b0) $display("FAIL single_out0: out %0d err %b want 0 0", out_a, err_a); else passes++;
  endtask

  task automatic test_credit();
    int acc = 0;
    @(negedge clk);
    ca.qvalid = 1'b1; ca.qid = 5'd0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (int'(out_a) !== ((i < 2) ? i : 2)) $display("FAIL credit_out[%0d]: got %0d want %0d", i, out_a, (i < 2) ? i : 2); else passes++;
      checks++; if (stall_a !== 32'((i < 2) ? 0 : i - 2)) $display("FAIL credit_stall[%0d]: got %0d want %0d", i, stall_a, (i < 2) ? 0 : i - 2); else passes++;
      if (ca.qready) acc++;
      @(negedge clk);
      ca.qid = 5'(acc);
    end
    #1;
    checks++; if (acc != 2) $display("FAIL credit_accepted: got %0d want 2", acc); else passes++;
    checks++; if (ca.qready !== 1'b0) $display("FAIL credit_qready: got %b want 0", ca.qready); else passes++;
    checks++; if (stall_a !== 32'd4) $display("FAIL credit_stall_total: got %0d want 4", stall_a); else passes++;
  endtask

  task automatic test_full_swap();
    ma.pvalid = 1'b1; ma.pid = 5'd0; ma.pdata = 32'h11; ca.pready = 1'b1;
    #1;
    checks++; if (ca.qready !== 1'b0) $display("FAIL swap_qready_full: got %b want 0", ca.qready); else passes++;
    checks++; if (ca.pvalid !== 1'b1 || ca.pid !== 5'd0) $display("FAIL swap_rsp: pvalid %b id %0d want 1 0", ca.pvalid, ca.pid); else passes++;
    @(negedge clk);
    ma.pvalid = 1'b0;
    #1;
    checks++; if (out_a !== 2'd1 || ca.qready !== 1'b1) $display("FAIL swap_next: out %0d qready %b want 1 1", out_a, ca.qready); else passes++;
    @(negedge clk);
    ca.qvalid = 1'b0;
    #1;
    checks++; if (out_a !== 2'd2) $display("FAIL swap_out2: got %0d want 2", out_a); else passes++;
    checks++; if (ma.qvalid !== 1'b1 || ma.qid !== 5'd2) $display("FAIL swap_mem_req: qvalid %b id %0d want 1 2", ma.qvalid, ma.qid); else passes++;
    ma.pvalid = 1'b1; ma.pid = 5'd1;
    @(negedge clk);
    ma.pid = 5'd2;
    @(negedge clk);
    ma.pvalid = 1'b0;
    #1;
    checks++; if (out_a !== 2'd0 || err_a !== 1'b0) $display("FAIL swap_drain: out %0d err %b want 0 0", out_a, err_a); else passes++;
    checks++; if (stall_a !== 32'd5) $display("FAIL swap_stall: got %0d want 5", stall_a); else passes++;
  endtask

  task automatic test_err();
    @(negedge clk);
    ma.pvalid = 1'b1; ma.pid = 5'd7; ca.pready = 1'b1;
    #1;
    checks++; if (ca.pvalid !== 1'b1 || ca.pid !== 5'd7) $display("FAIL err_delivered: pvalid %b id %0d want 1 7", ca.pvalid, ca.pid); else passes++;
    @(negedge clk);
    ma.pvalid = 1'b0;
    #1;
    checks++; if (err_a !== 1'b1) $display("FAIL err_set: got %b want 1", err_a); else passes++;
    checks++; if (out_a !== 2'd0) $display("FAIL err_no_underflow: got %0d want 0", out_a); else passes++;
    clr = 1'b1; ma.pvalid = 1'b1;
    @(negedge clk);
    clr = 1'b0; ma.pvalid = 1'b0;
    #1;
    checks++; if (err_a !== 1'b0) $display("FAIL err_clr_wins: got %b want 0", err_a); else passes++;
    checks++; if (stall_a !== 32'd0) $display("FAIL err_clr_stall: got %0d want 0", stall_a); else passes++;
    checks++; if (out_a !== 2'd0) $display("FAIL err_clr_out: got %0d want 0", out_a); else passes++;
  endtask

  task automatic traffic(input string tag, input int n, input bit bp);
    txn_t req_q[$], mq[$], rsp_q[$];
    txn_t cur, e;
    int sent = 0, recv = 0, cyc = 0, bubbles = 0;
    logic [31:0] stall0;
    stall0 = stall_b;
    cur = '{id: 5'($urandom), data: $urandom};
    while (recv < n && cyc < 20000) begin
      @(negedge clk);
      cb.qvalid = sent < n;
      cb.qid = cur.id; cb.qdata = cur.data; cb.qaddr = ~cur.data;
      cb.qstrb = cur.data[3:0]; cb.qwrite = cur.data[4]; cb.qamo = cur.data[8:5];
      mb.qready = !bp || $urandom_range(0, 3) != 0;
      cb.pready = !bp || $urandom_range(0, 3) != 0;
      mb.pvalid = mq.size() > 0 && (!bp || mb.pvalid || $urandom_range(0, 3) != 0);
      if (mq.size() > 0) begin
        mb.pid = mq[0].id; mb.pdata = mq[0].data ^ 32'h5A5A5A5A; mb.perror = mq[0].id[0];
      end
      #1;
      if (cb.qvalid && !cb.qready) bubbles++;
      if (cb.qvalid && cb.qready) begin
        req_q.push_back(cur);
        rsp_q.push_back('{id: cur.id, data: cur.data ^ 32'h5A5A5A5A});
        sent++;
        cur = '{id: 5'($urandom), data: $urandom};
      end
      if (mb.qvalid && mb.qready) begin
        checks++;
        if (req_q.size() == 0) $display("FAIL %s_req: unexpected mem request id %0d", tag, mb.qid);
        else begin
          e = req_q.pop_front();
          if (mb.qid !== e.id || mb.qdata !== e.data || mb.qaddr !== ~e.data || mb.qstrb !== e.data[3:0] || mb.qwrite !== e.data[4] || mb.qamo !== e.data[8:5])
            $display("FAIL %s_req: id %0d data %0h addr %0h want %0d %0h %0h", tag, mb.qid, mb.qdata, mb.qaddr, e.id, e.data, ~e.data);
          else passes++;
        end
        mq.push_back('{id: mb.qid, data: mb.qdata});
      end
      if (mb.pvalid && mb.pready) void'(mq.pop_front());
      if (cb.pvalid && cb.pready) begin
        checks++;
        if (rsp_q.size() == 0) $display("FAIL %s_rsp: unexpected response id %0d", tag, cb.pid);
        else begin
          e = rsp_q.pop_front();
          if (cb.pid !== e.id || cb.pdata !== e.data || cb.perror !== e.id[0])
            $display("FAIL %s_rsp: id %0d data %0h err %b want %0d %0h %b", tag, cb.pid, cb.pdata, cb.perror, e.id, e.data, e.id[0]);
          else passes++;
        end
        recv++;
      end
      cyc++;
    end
    @(negedge clk);
    cb.qvalid = 1'b0; mb.pvalid = 1'b0; mb.qready = 1'b1; cb.pready = 1'b1;
    #1;
    checks++; if (recv != n) $display("FAIL %s_count: got %0d want %0d responses", tag, recv, n); else passes++;
    checks++; if (out_b !== 5'd0 || err_b !== 1'b0) $display("FAIL %s_idle: out %0d err %b want 0 0", tag, out_b, err_b); else passes++;
    checks++; if (stall_b - stall0 !== 32'(bubbles)) $display("FAIL %s_stall: got %0d want %0d", tag, stall_b - stall0, bubbles); else passes++;
    if (!bp) begin
      checks++; if (bubbles != 0) $display("FAIL %s_bubbles: got %0d want 0", tag, bubbles); else passes++;
    end
  endtask

  task automatic test_random();
    traffic("random", 1000, 1'b1);
  endtask

  task automatic test_back_to_back();
    traffic("b2b", 100, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mb.qready = 1'b0; cb.qvalid = 1'b1; cb.qid = 5'd9;
    repeat (3) @(negedge clk);
    cb.qvalid = 1'b0;
    #1;
    checks++; if (out_b !== 5'd3) $display("FAIL rstmid_out3: got %0d want 3", out_b); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (out_b !== 5'd0) $display("FAIL rstmid_out0: got %0d want 0", out_b); else passes++;
    checks++; if (mb.qvalid !== 1'b0 || cb.pvalid !== 1'b0) $display("FAIL rstmid_valids: qv %b pv %b want 0 0", mb.qvalid, cb.pvalid); else passes++;
    mb.qready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    #1;
    checks++; if (mb.qvalid !== 1'b0) $display("FAIL rstmid_flushed: got %b want 0", mb.qvalid); else passes++;
    traffic("post_rst", 4, 1'b0);
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_credit();
    test_full_swap();
    test_err();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
